// File: rtl/peridot_servo_stepgen.sv
// peridot_servo_stepgen
//   Shared step/frame timebase for the RC servo PWM channels. An exact-average
//   fractional divider turns clk into STEPNUM*FRAMERATE step strobes per
//   second. The block broadcasts the strobe, the current step number and a
//   frame-aligned enable to every channel generator. A small control/status
//   register carries the run request and the frame interrupt.
//
// Ports
//   clk            in   1   system clock, rising edge
//   reset_n        in   1   asynchronous active-low reset
//   reg_write      in   1   control write strobe, one clk
//   reg_writedata  in   8   b0 run_req, b1 irq_ena, b2 irq_clr (write-1)
//   reg_readdata   out  8   {5'b0, irq_flag, irq_ena, pwm_enable}
//   pwm_enable     out  1   run status, changes only at frame start
//   pwm_timing     out  1   one-clk step strobe
//   step_num       out  13  current step, stable between strobes
//   frame_start    out  1   one-clk pulse on the strobe where step_num wraps to 0
//   irq            out  1   irq_flag & irq_ena
module peridot_servo_stepgen #(
   parameter int unsigned CLOCKFREQ = 100000000,
   parameter int unsigned FRAMERATE = 50,
   parameter int unsigned STEPNUM   = 2560
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        reg_write,
   input  logic [7:0]  reg_writedata,
   output logic [7:0]  reg_readdata,
   output logic        pwm_enable,
   output logic        pwm_timing,
   output logic [12:0] step_num,
   output logic        frame_start,
   output logic        irq
);

   localparam int unsigned STEPRATE = STEPNUM * FRAMERATE;
   localparam logic [32:0] CF33      = 33'(CLOCKFREQ);
   localparam logic [32:0] SR33      = 33'(STEPRATE);
   localparam logic [12:0] STEP_LAST = 13'(STEPNUM - 1);

   generate
      if (CLOCKFREQ < STEPRATE) begin : g_bad_rate
         $error("peridot_servo_stepgen: CLOCKFREQ must be >= STEPNUM*FRAMERATE");
      end
      if (STEPNUM < 1 || STEPNUM > 8192) begin : g_bad_stepnum
         $error("peridot_servo_stepgen: STEPNUM must be in 1..8192");
      end
   endgenerate

   logic [31:0] acc_q, acc_d;
   logic [32:0] sum;
   logic        tick;
   logic        wrap;
   logic [12:0] step_q, step_d;
   logic        timing_q;
   logic        fs_q;
   logic        en_q;
   logic        run_q;
   logic        ena_q;
   logic        flag_q;

   // Accumulator stays below CLOCKFREQ, so the 33-bit sum can never overflow
   // and subtracting CLOCKFREQ always lands back inside 32 bits.
   always_comb begin
      sum    = {1'b0, acc_q} + SR33;
      tick   = (sum >= CF33);
      acc_d  = tick ? 32'(sum - CF33) : sum[31:0];
      wrap   = (step_q == STEP_LAST);
      step_d = step_q;
      if (tick) begin
         step_d = wrap ? 13'd0 : step_q + 13'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q    <= 32'd0;
         step_q   <= STEP_LAST;
         timing_q <= 1'b0;
         fs_q     <= 1'b0;
         en_q     <= 1'b0;
         run_q    <= 1'b0;
         ena_q    <= 1'b0;
         flag_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         step_q   <= step_d;
         timing_q <= tick;
         fs_q     <= tick && wrap;
         // Enable is sampled only at the frame boundary so a channel never
         // emits a truncated pulse when run_req toggles mid-frame.
         if (tick && wrap) begin
            en_q <= run_q;
         end
         if (reg_write) begin
            run_q <= reg_writedata[0];
            ena_q <= reg_writedata[1];
         end
         // Setting on the frame_start cycle takes priority over a clear.
         if (fs_q) begin
            flag_q <= 1'b1;
         end else if (reg_write && reg_writedata[2]) begin
            flag_q <= 1'b0;
         end
      end
   end

   assign pwm_enable   = en_q;
   assign pwm_timing   = timing_q;
   assign step_num     = step_q;
   assign frame_start  = fs_q;
   assign irq          = flag_q & ena_q;
   assign reg_readdata = {5'b0, flag_q, ena_q, en_q};

endmodule

// File: tb/tb_peridot_servo_stepgen.sv
// Testbench for peridot_servo_stepgen. Instance A uses CLOCKFREQ=384000 with
// default frame settings; instance B uses CLOCKFREQ=25, FRAMERATE=2, STEPNUM=8.
// Both run on the same clock and reset; outputs are compared every cycle to a
// closed-form model (strobe count after e edges = floor(e*STEPRATE/CLOCKFREQ)).
module tb_peridot_servo_stepgen;

   localparam longint CF_A = 384000, SR_A = 128000, SN_A = 2560;
   localparam longint CF_B = 25,     SR_B = 16,     SN_B = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        reg_write;
   logic [7:0]  reg_writedata;
   logic [7:0]  reg_readdata;
   logic        pwm_enable, pwm_timing, frame_start, irq;
   logic [12:0] step_num;

   logic        b_write;
   logic [7:0]  b_wdata;
   logic [7:0]  b_rd;
   logic        b_en, b_timing, b_fs, b_irq;
   logic [12:0] b_step;

   always #5 clk = ~clk;

   peridot_servo_stepgen #(.CLOCKFREQ(384000), .FRAMERATE(50), .STEPNUM(2560)) dut_a (
      .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .reg_writedata(reg_writedata),
      .reg_readdata(reg_readdata), .pwm_enable(pwm_enable), .pwm_timing(pwm_timing),
      .step_num(step_num), .frame_start(frame_start), .irq(irq));

   peridot_servo_stepgen #(.CLOCKFREQ(25), .FRAMERATE(2), .STEPNUM(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .reg_write(b_write), .reg_writedata(b_wdata),
      .reg_readdata(b_rd), .pwm_enable(b_en), .pwm_timing(b_timing),
      .step_num(b_step), .frame_start(b_fs), .irq(b_irq));

   int     tests = 0;
   int     fails = 0;
   longint e;
   int     fs_cnt, b_cnt;
   longint last_b;
   bit     m_run, m_ena, m_flag, m_en, wpend;
   logic [7:0] wd;

   // Edges since reset release.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) e <= 0;
      else          e <= e + 1;
   end

   function automatic longint strb(input longint ee, input longint sr, input longint cf);
      return (ee <= 0) ? 0 : (ee * sr) / cf;
   endfunction

   function automatic longint mstep(input longint ee, input longint sr, input longint cf,
                                    input longint sn);
      return (strb(ee, sr, cf) + sn - 1) % sn;
   endfunction

   function automatic bit mpt(input longint ee, input longint sr, input longint cf);
      return strb(ee, sr, cf) != strb(ee - 1, sr, cf);
   endfunction

   function automatic bit mfs(input longint ee, input longint sr, input longint cf,
                              input longint sn);
      return mpt(ee, sr, cf) && (mstep(ee, sr, cf, sn) == 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      bit fs_now, fs_prev, old_run;
      longint gap;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         fs_now  = mfs(e, SR_A, CF_A, SN_A);
         fs_prev = mfs(e - 1, SR_A, CF_A, SN_A);
         old_run = m_run;
         if (wpend) begin
            m_run = wd[0];
            m_ena = wd[1];
            if (wd[2]) m_flag = 1'b0;
            wpend = 1'b0;
            reg_write = 1'b0;
         end
         if (fs_prev) m_flag = 1'b1;
         if (fs_now)  m_en = old_run;
         check("a_timing", 32'(pwm_timing), 32'(mpt(e, SR_A, CF_A)));
         check("a_step", 32'(step_num), 32'(mstep(e, SR_A, CF_A, SN_A)));
         check("a_fs", 32'(frame_start), 32'(fs_now));
         check("a_enable", 32'(pwm_enable), 32'(m_en));
         check("a_irq", 32'(irq), 32'(m_flag & m_ena));
         check("a_readdata", 32'(reg_readdata), 32'({m_flag, m_ena, m_en}));
         check("b_timing", 32'(b_timing), 32'(mpt(e, SR_B, CF_B)));
         check("b_step", 32'(b_step), 32'(mstep(e, SR_B, CF_B, SN_B)));
         check("b_fs", 32'(b_fs), 32'(mfs(e, SR_B, CF_B, SN_B)));
         check("b_acc", dut_b.acc_q, 32'((e * SR_B) % CF_B));
         check("b_enable_irq", 32'({b_en, b_irq, b_rd[1:0]}), 32'd0);
         if (frame_start) fs_cnt++;
         if (b_timing) begin
            b_cnt++;
            if (last_b != 0) begin
               gap = e - last_b;
               check("t2_gap", 32'((gap == 1) || (gap == 2)), 32'd1);
            end
            last_b = e;
         end
      end
   endtask

   task automatic wr(input logic [7:0] d);
      reg_write     = 1'b1;
      reg_writedata = d;
      wd            = d;
      wpend         = 1'b1;
      step(1);
   endtask

   task automatic run_until_fs(input string tag, input int bound);
      int k = 0;
      do begin
         step(1);
         k++;
      end while (!frame_start && k < bound);
      check(tag, 32'(frame_start), 32'd1);
   endtask

   task automatic run_until_step(input string tag, input logic [12:0] target, input int bound);
      int k = 0;
      while (step_num != target && k < bound) begin
         step(1);
         k++;
      end
      check(tag, 32'(step_num), 32'(target));
   endtask

   task automatic chk_rst(input string tag);
      check({tag, "_enable"}, 32'(pwm_enable), 32'd0);
      check({tag, "_timing"}, 32'(pwm_timing), 32'd0);
      check({tag, "_step"}, 32'(step_num), 32'd2559);
      check({tag, "_fs"}, 32'(frame_start), 32'd0);
      check({tag, "_irq"}, 32'(irq), 32'd0);
      check({tag, "_readdata"}, 32'(reg_readdata), 32'd0);
      check({tag, "_b_step"}, 32'(b_step), 32'd7);
   endtask

   task automatic model_reset();
      m_run = 0; m_ena = 0; m_flag = 0; m_en = 0; wpend = 0; last_b = 0;
      reg_write = 1'b0;
   endtask

   initial begin
      logic [12:0] r;
      reset_n       = 1'b0;
      reg_writedata = 8'h00;
      b_write       = 1'b0;
      b_wdata       = 8'h00;
      wd            = 8'h00;
      fs_cnt        = 0;
      b_cnt         = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_rst("reset");
      reset_n = 1'b1;

      // T1: strobe every third clock, one frame_start per 7680 clocks, wrap seen.
      fs_cnt = 0;
      step(7680);
      check("t1_fs_per_frame", 32'(fs_cnt), 32'd1);
      step(10);

      // T2: any 25-clock window of instance B holds exactly 16 strobes.
      b_cnt = 0;
      step(25);
      check("t2_16_per_25", 32'(b_cnt), 32'd16);
      b_cnt = 0;
      step(25);
      check("t2_16_per_25b", 32'(b_cnt), 32'd16);

      // T3: run request takes effect only at frame boundaries.
      r = 13'($urandom_range(60, 2400));
      run_until_step("t3_reach_on", r, 8000);
      wr(8'h01);
      check("t3_not_yet", 32'(pwm_enable), 32'd0);
      run_until_fs("t3_wait_rise", 8000);
      check("t3_rise", 32'(pwm_enable), 32'd1);
      r = 13'($urandom_range(1, 50));
      run_until_step("t3_reach_off", r, 8000);
      wr(8'h00);
      check("t3_hold", 32'(pwm_enable), 32'd1);
      run_until_fs("t3_wait_fall", 8000);
      check("t3_fall", 32'(pwm_enable), 32'd0);

      // T4: frame interrupt set, clear, and set-wins on coincident clear.
      wr(8'h02);
      run_until_fs("t4_wait_fs", 8000);
      step(1);
      check("t4_irq_set", 32'(irq), 32'd1);
      check("t4_readdata", 32'(reg_readdata), 32'h06);
      wr(8'h06);
      check("t4_irq_clr", 32'(irq), 32'd0);
      run_until_fs("t4_wait_fs2", 8000);
      wr(8'h06);
      check("t4_set_wins", 32'(irq), 32'd1);

      // Random register traffic, tracked by the model.
      for (int i = 0; i < 8; i++) begin
         step($urandom_range(1, 300));
         wr(8'($urandom_range(0, 255)));
      end

      // T5: asynchronous reset mid-frame while running.
      wr(8'h03);
      run_until_fs("t5_wait_run", 8000);
      check("t5_running", 32'(pwm_enable), 32'd1);
      run_until_step("t5_reach", 13'd1234, 8000);
      check("t5_enabled_at_1234", 32'(pwm_enable), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk_rst("t5_async");
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
      begin
         int k = 0;
         do begin
            step(1);
            k++;
         end while (!pwm_timing && k < 10);
      end
      check("t5_first_strobe", 32'(pwm_timing), 32'd1);
      check("t5_first_step", 32'(step_num), 32'd0);
      check("t5_first_enable", 32'(pwm_enable), 32'd0);
      step(30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
